md_issue_stage: RTL and testbench
=================================

# md_issue_stage

Sequential front/back end for the combinational signed multiply/divide unit. Accepts operand pairs and an opcode through a valid/ready handshake and buffers them in a small FIFO. Issues the FIFO head to the unit and registers the unit's {m, r, error} outputs into a result register with its own valid/ready handshake. Keeps saturating counters of completed operations and errored operations for status readout.

## Interface
- N, 5, operand and result width (signed two's complement)
- DEPTH, 4, operand FIFO depth; power of two, ≥ 2
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request valid
- in_ready  out  1  stage can accept a request
- in_a  in  N  signed operand a (dividend / multiplicand)
- in_b  in  N  signed operand b (divisor / multiplier)
- in_op  in  2  00 divide, 01 multiply, 10/11 reserved
- md_a  out  N  to unit operand a
- md_b  out  N  to unit operand b
- md_sel  out  2  to unit opcode
- md_m  in  N  from unit: quotient (div) / product high half (mul)
- md_r  in  N  from unit: remainder (div) / product low half (mul)
- md_error  in  1  from unit: divide-by-zero flag
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts result
- out_m, out_r  out  N each  registered result
- out_error  out  1  registered error flag
- op_count  out  16  results delivered (saturating)
- err_count  out  16  delivered results with out_error=1 (saturating)

## Operation
- FIFO: DEPTH entries of {a, b, op}. Push when in_valid && in_ready. in_ready = (count != DEPTH); no bypass at full, even if a pop happens in the same cycle.
- md_a/md_b/md_sel always driven from the FIFO head (zeros when empty); the unit settles within the cycle.
- Result register FSM:
  - EMPTY: out_valid=0. If FIFO non-empty, capture head → FULL and pop.
  - FULL: out_valid=1. If out_ready: if FIFO non-empty, capture the new head and pop (stay FULL); else → EMPTY. If !out_ready: hold everything stable.
- Capture rules:
  - op 00/01: out_m=md_m, out_r=md_r, out_error=md_error.
  - op 10/11: out_m=0, out_r=0, out_error=1; unit outputs ignored.
  - For op 01, out_error is forced to 0.
- Counters: on out_valid && out_ready, op_count += 1 and, if out_error, err_count += 1. Both saturate at 16'hFFFF.
- Reset: FIFO flushed (count=0, pointers 0), FSM → EMPTY, counters 0. Any in-flight request or undelivered result is discarded.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset values: in_ready=1, out_valid=0, out_m=0, out_r=0, out_error=0, op_count=0, err_count=0, md_a=md_b=md_sel=0.
- Latency: request accepted at edge k appears at the head after edge k; the result is captured at edge k+1; out_valid=1 in the cycle after edge k+1. This gives 2 cycles from acceptance to out_valid.
- Throughput: 1 result/cycle with in_valid and out_ready held high.
- Outputs are stable while out_valid && !out_ready.
- Results are delivered in request order; no result is dropped or duplicated.
- rst asserted mid-stream takes effect at the next edge and overrides all handshakes in that cycle.

## Test plan
- Divide: a=13, b=2, op=00 → out_valid two cycles after acceptance with out_m=6, out_r=1, out_error=0; op_count=1 after handshake.
- Multiply: a=-6, b=7, op=01 → out_m=-2 (5'b11110), out_r=-10 (5'b10110), i.e. -42; out_error=0.
- Divide by zero: a=13, b=0, op=00 → out_error=1; err_count=1 after handshake. Reserved op=10 with any operands → out_m=0, out_r=0, out_error=1.
- Backpressure:
  - Stimulus: out_ready=0, offer 6 requests back-to-back.
  - Required: first 5 accepted (1 in the result register + 4 in the FIFO); in_ready=0 afterwards; outputs stable.
  - Then raise out_ready: 5 results delivered in order, one per cycle.
- Streaming: 30 random requests with random in_valid/out_ready → every result matches a golden model in order; op_count=30, err_count equals the number of b=0 divides plus reserved ops.
- Reset mid-stream: with 3 requests queued and out_valid=1, pulse rst for 1 cycle → out_valid=0, in_ready=1, counters 0, and no stale results afterwards.

Source files
------------

// File: rtl/md_issue_stage.sv
// Issue stage for the combinational signed multiply/divide unit: operand FIFO in front,
// registered result with valid/ready behind, and saturating delivery/error counters.
module md_issue_stage #(
  parameter int N     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [1:0]   in_op,
  output logic [N-1:0] md_a,
  output logic [N-1:0] md_b,
  output logic [1:0]   md_sel,
  input  logic [N-1:0] md_m,
  input  logic [N-1:0] md_r,
  input  logic         md_error,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_m,
  output logic [N-1:0] out_r,
  output logic         out_error,
  output logic [15:0]  op_count,
  output logic [15:0]  err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  logic [N-1:0]  a_mem  [DEPTH];
  logic [N-1:0]  b_mem  [DEPTH];
  logic [1:0]    op_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  state_t        state_reg, state_next;
  logic          capture;
  logic          push;
  logic          fifo_empty;
  logic          deliver;
  logic [N-1:0]  out_m_reg, out_r_reg;
  logic          out_error_reg;
  logic [15:0]   op_count_reg, err_count_reg;

  assign fifo_empty = (count_reg == '0);
  assign in_ready   = (count_reg != DEPTH_CNT);
  assign push       = in_valid && in_ready;
  assign out_valid  = (state_reg == S_FULL);
  assign deliver    = out_valid && out_ready;

  // The head feeds the unit combinationally so its result is ready to capture this cycle.
  assign md_a   = fifo_empty ? '0 : a_mem[rd_ptr_reg];
  assign md_b   = fifo_empty ? '0 : b_mem[rd_ptr_reg];
  assign md_sel = fifo_empty ? '0 : op_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_reg]  <= in_a;
      b_mem[wr_ptr_reg]  <= in_b;
      op_mem[wr_ptr_reg] <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)    wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (capture) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, capture})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      S_EMPTY: begin
        if (!fifo_empty) begin
          capture    = 1'b1;
          state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (out_ready) begin
          if (!fifo_empty) capture    = 1'b1;
          else             state_next = S_EMPTY;
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  // Multiply never reports an error; reserved opcodes always do, regardless of the unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_m_reg     <= '0;
      out_r_reg     <= '0;
      out_error_reg <= 1'b0;
    end else if (capture) begin
      case (md_sel)
        2'b00: begin
          out_m_reg     <= md_m;
          out_r_reg     <= md_r;
          out_error_reg <= md_error;
        end
        2'b01: begin
          out_m_reg     <= md_m;
          out_r_reg     <= md_r;
          out_error_reg <= 1'b0;
        end
        default: begin
          out_m_reg     <= '0;
          out_r_reg     <= '0;
          out_error_reg <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg  <= '0;
      err_count_reg <= '0;
    end else if (deliver) begin
      if (op_count_reg != 16'hFFFF) op_count_reg <= op_count_reg + 16'd1;
      if (out_error_reg && (err_count_reg != 16'hFFFF)) err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign out_m     = out_m_reg;
  assign out_r     = out_r_reg;
  assign out_error = out_error_reg;
  assign op_count  = op_count_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_md_issue_stage.sv
// Self-checking bench for md_issue_stage: a behavioural multiply/divide unit plus an
// in-order result queue model, checked every cycle under directed and random traffic.
module tb_md_issue_stage;

  localparam int N = 5;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a, in_b;
  logic [1:0]   in_op;
  logic [N-1:0] md_a, md_b;
  logic [1:0]   md_sel;
  logic [N-1:0] md_m, md_r;
  logic         md_error;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_m, out_r;
  logic         out_error;
  logic [15:0]  op_count, err_count;

  md_issue_stage #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .md_a(md_a), .md_b(md_b), .md_sel(md_sel),
    .md_m(md_m), .md_r(md_r), .md_error(md_error),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_m(out_m), .out_r(out_r), .out_error(out_error),
    .op_count(op_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Unit model. It raises its error flag on multiply-by-zero and emits junk on
  // reserved opcodes so the stage's overrides are actually exercised.
  int ua, ub, uq, urm, up;
  always_comb begin
    ua = $signed(md_a);
    ub = $signed(md_b);
    uq = 0; urm = 0; up = 0;
    md_m = '0; md_r = '0; md_error = 1'b0;
    case (md_sel)
      2'b00: begin
        if (ub == 0) md_error = 1'b1;
        else begin
          uq = ua / ub; urm = ua % ub;
          md_m = uq[N-1:0]; md_r = urm[N-1:0];
        end
      end
      2'b01: begin
        up = ua * ub;
        md_m = up[2*N-1:N]; md_r = up[N-1:0];
        md_error = (ub == 0);
      end
      default: begin
        md_m = md_a ^ 5'h0a; md_r = md_b; md_error = 1'b0;
      end
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected {m, r, error} straight from the arithmetic definition of each opcode.
  function automatic logic [2*N:0] golden(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [1:0] op);
    int sa, sb, q, rm, p;
    logic [2*N-1:0] pl;
    sa = $signed(a); sb = $signed(b);
    case (op)
      2'b00: begin
        if (sb == 0) return {{(2*N){1'b0}}, 1'b1};
        q = sa / sb; rm = sa % sb;
        return {q[N-1:0], rm[N-1:0], 1'b0};
      end
      2'b01: begin
        p = sa * sb; pl = p[2*N-1:0];
        return {pl, 1'b0};
      end
      default: return {{(2*N){1'b0}}, 1'b1};
    endcase
  endfunction

  // Model state: every accepted request not yet delivered, oldest first.
  logic [2*N:0] res_q[$];
  int m_fifo = 0;
  bit m_res_valid = 0;
  int m_ops = 0, m_errs = 0;
  int n_acc = 0, n_del = 0;

  task automatic step();
    bit push, pop, deliver;
    logic [2*N:0] exp_res;
    check("in_ready", 32'(in_ready), 32'(m_fifo != DEPTH));
    check("out_valid", 32'(out_valid), 32'(m_res_valid));
    check("op_count", 32'(op_count), 32'(m_ops));
    check("err_count", 32'(err_count), 32'(m_errs));
    if (m_res_valid && res_q.size() > 0) begin
      exp_res = res_q[0];
      check("out_m", 32'(out_m), 32'(exp_res[2*N:N+1]));
      check("out_r", 32'(out_r), 32'(exp_res[N:1]));
      check("out_error", 32'(out_error), 32'(exp_res[0]));
    end
    deliver = m_res_valid && out_ready;
    push = in_valid && (m_fifo != DEPTH);
    pop = (m_fifo != 0) && (!m_res_valid || out_ready);
    if (deliver) begin
      exp_res = res_q.pop_front();
      n_del++;
      if (m_ops != 65535) m_ops++;
      if (exp_res[0] && m_errs != 65535) m_errs++;
      $display("deliver m=%0d r=%0d err=%0b", $signed(out_m), $signed(out_r), out_error);
    end
    if (push) begin
      res_q.push_back(golden(in_a, in_b, in_op));
      n_acc++;
      $display("accept a=%0d b=%0d op=%0d", $signed(in_a), $signed(in_b), in_op);
    end
    m_fifo = m_fifo + int'(push) - int'(pop);
    m_res_valid = pop || (m_res_valid && !out_ready);
    if (rst) begin
      res_q.delete();
      m_fifo = 0; m_res_valid = 0; m_ops = 0; m_errs = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    n_acc = 0; n_del = 0;
  endtask

  int exp_err_stream;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_m", 32'(out_m), 32'd0);
    check("rst_out_error", 32'(out_error), 32'd0);
    check("rst_md_a", 32'(md_a), 32'd0);
    check("rst_md_sel", 32'(md_sel), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);

    // Divide 13/2: visible two cycles after acceptance.
    in_valid = 1'b1; in_a = 5'd13; in_b = 5'd2; in_op = 2'b00;
    step();
    in_valid = 1'b0;
    check("div_lat0", 32'(out_valid), 32'd0);
    step();
    check("div_valid", 32'(out_valid), 32'd1);
    check("div_m", 32'(out_m), 32'd6);
    check("div_r", 32'(out_r), 32'd1);
    out_ready = 1'b1;
    step();
    check("div_op_count", 32'(op_count), 32'd1);
    out_ready = 1'b0;

    // Multiply -6 * 7 = -42.
    in_valid = 1'b1; in_a = 5'b11010; in_b = 5'd7; in_op = 2'b01;
    step();
    in_valid = 1'b0;
    step();
    check("mul_m", 32'(out_m), 32'h1e);
    check("mul_r", 32'(out_r), 32'h16);
    check("mul_error", 32'(out_error), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Divide by zero, then a reserved opcode.
    in_valid = 1'b1; in_a = 5'd13; in_b = 5'd0; in_op = 2'b00;
    step();
    in_a = 5'($urandom); in_b = 5'($urandom); in_op = 2'b10;
    step();
    in_valid = 1'b0;
    check("dz_error", 32'(out_error), 32'd1);
    out_ready = 1'b1;
    step();
    check("dz_err_count", 32'(err_count), 32'd1);
    check("rsv_m", 32'(out_m), 32'd0);
    check("rsv_r", 32'(out_r), 32'd0);
    check("rsv_error", 32'(out_error), 32'd1);
    step();
    out_ready = 1'b0;

    // Backpressure: six offers, only five fit.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = 5'(i + 3); in_b = 5'(i + 1); in_op = 2'(i % 2);
      step();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(n_acc), 32'd5);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("bp_delivered", 32'(n_del), 32'd5);
    check("bp_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Random streaming of 30 requests.
    do_reset();
    exp_err_stream = 0;
    for (int cyc = 0; cyc < 2000 && (n_acc < 30 || res_q.size() > 0); cyc++) begin
      in_valid = (n_acc < 30) && ($urandom_range(0, 2) != 0);
      in_a = 5'($urandom);
      in_b = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      in_op = 2'($urandom_range(0, 5) > 3 ? $urandom_range(2, 3) : $urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready && ((in_op == 2'b00 && in_b == 5'd0) || in_op[1]))
        exp_err_stream++;
      step();
    end
    in_valid = 1'b0;
    check("stream_drained", 32'(res_q.size()), 32'd0);
    check("stream_op_count", 32'(op_count), 32'd30);
    check("stream_err_count", 32'(err_count), 32'(exp_err_stream));

    // Reset with a result held and three more queued.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 5'($urandom); in_b = 5'd3; in_op = 2'b01;
      step();
    end
    in_valid = 1'b0;
    step();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_ops", 32'(op_count), 32'd0);
    check("mid_rst_errs", 32'(err_count), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("no_stale", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
